// File: rtl/clock_divider_cfg_ctrl_if.sv
// Config request bus into the clock divider config stage: valid/ready plus ratio/enable payload.
interface clock_divider_cfg_ctrl_if #(
    parameter int RATIO_WIDTH = 5
) ();
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [RATIO_WIDTH-1:0] cfg_ratio;
    logic                   cfg_en;

    modport master (output cfg_valid, cfg_ratio, cfg_en, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ratio, cfg_en, output cfg_ready);
endinterface

// File: rtl/clock_divider_cfg_ctrl.sv
// Config stage for the clock divider: takes ratio/enable updates over valid/ready and applies them
// only at a divided-clock period boundary (or after a bounded wait) so the divider never emits a runt.
module clock_divider_cfg_ctrl #(
    parameter int RATIO_WIDTH = 5,
    parameter int RESET_RATIO = 1,
    parameter int MAX_WAIT    = 64
) (
    input  logic                      i_ref_clk,
    input  logic                      i_rst_n,
    clock_divider_cfg_ctrl_if.slave   cfg,
    input  logic                      i_div_clk,
    output logic [RATIO_WIDTH-1:0]    o_div_ratio,
    output logic                      o_clk_en,
    output logic                      o_busy,
    output logic                      o_cfg_err,
    output logic                      o_timeout
);
    localparam int CW = $clog2(MAX_WAIT) + 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, APPLY} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          wait_cnt, wait_cnt_nxt;
    logic                   apply_phase;
    logic                   div_clk_q;
    logic [RATIO_WIDTH-1:0] pend_ratio;
    logic                   pend_en;
    logic                   accept, reject, bypass, boundary, wait_done;
    logic                   latch_req, load_out, err_nxt, timeout_nxt;

    assign cfg.cfg_ready = (state == IDLE);
    assign o_busy        = (state != IDLE);

    assign accept    = cfg.cfg_valid & cfg.cfg_ready;
    assign reject    = cfg.cfg_en & (cfg.cfg_ratio == '0);
    // In bypass the divider output follows the ref clock, so there is no boundary worth waiting for.
    assign bypass    = ~o_clk_en | (o_div_ratio <= RATIO_WIDTH'(1));
    assign boundary  = i_div_clk & ~div_clk_q;
    assign wait_done = (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        latch_req    = 1'b0;
        load_out     = 1'b0;
        err_nxt      = 1'b0;
        timeout_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (reject) begin
                        err_nxt = 1'b1;
                    end else begin
                        latch_req    = 1'b1;
                        wait_cnt_nxt = '0;
                        state_nxt    = bypass ? APPLY : WAIT_EDGE;
                    end
                end
            end
            WAIT_EDGE: begin
                if (boundary) begin
                    state_nxt = APPLY;
                end else if (wait_done) begin
                    state_nxt   = APPLY;
                    timeout_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + CW'(1);
                end
            end
            APPLY: begin
                // Two cycles in APPLY: the update lands on the 2nd edge after the decision edge.
                if (apply_phase) begin
                    load_out  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            apply_phase <= 1'b0;
            div_clk_q   <= 1'b0;
            pend_ratio  <= RATIO_WIDTH'(RESET_RATIO);
            pend_en     <= 1'b0;
            o_div_ratio <= RATIO_WIDTH'(RESET_RATIO);
            o_clk_en    <= 1'b0;
            o_cfg_err   <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            apply_phase <= (state == APPLY) & ~apply_phase;
            div_clk_q   <= i_div_clk;
            o_cfg_err   <= err_nxt;
            o_timeout   <= timeout_nxt;
            if (latch_req) begin
                pend_ratio <= cfg.cfg_ratio;
                pend_en    <= cfg.cfg_en;
            end
            if (load_out) begin
                o_div_ratio <= pend_ratio;
                o_clk_en    <= pend_en;
            end
        end
    end
endmodule
